// File: rtl/cmp_rgb_led_driver.sv
`default_nettype none
// ============================================================================
//  Module   : cmp_rgb_led_driver
//  Purpose  : Board RGB LED driver for the 2-bit magnitude comparator flags.
//             Synchronises and debounces {r,g,b}. Flashes each newly accepted
//             pattern at full brightness, then holds it at a PWM-dimmed level.
//  Option   : CMP_LED_BLINK_EN - when defined, the dimmed pattern also blinks
//             with a period of 2**BLINK_BITS cycles (lit half first).
//  Revision : 1.0 - initial release
// ============================================================================
module cmp_rgb_led_driver #(
  parameter int PWM_BITS      = 8,
  parameter int DUTY          = 64,
  parameter int STABLE_CYCLES = 16,
  parameter int FLASH_CYCLES  = 1000,
  parameter int BLINK_BITS    = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       r_in,
  input  logic       g_in,
  input  logic       b_in,
  output logic       led_r,
  output logic       led_g,
  output logic       led_b,
  output logic [2:0] pattern,
  output logic       pattern_valid
);

  // --------------------------------------------------------------------------
  // Parameter legality
  // --------------------------------------------------------------------------
  generate
    if ((DUTY < 0) || (DUTY > (2 ** PWM_BITS) - 1)) begin : g_bad_duty
      $error("cmp_rgb_led_driver: DUTY out of range 0..2**PWM_BITS-1");
    end
    if (STABLE_CYCLES < 1) begin : g_bad_stable
      $error("cmp_rgb_led_driver: STABLE_CYCLES must be >= 1");
    end
    if (FLASH_CYCLES < 1) begin : g_bad_flash
      $error("cmp_rgb_led_driver: FLASH_CYCLES must be >= 1");
    end
    if (PWM_BITS < 1) begin : g_bad_pwm
      $error("cmp_rgb_led_driver: PWM_BITS must be >= 1");
    end
    if (BLINK_BITS < 1) begin : g_bad_blink
      $error("cmp_rgb_led_driver: BLINK_BITS must be >= 1");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Derived constants
  // --------------------------------------------------------------------------
  localparam int STAB_W  = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam int FLASH_W = (FLASH_CYCLES  > 1) ? $clog2(FLASH_CYCLES)  : 1;

  localparam logic [STAB_W-1:0]   STAB_MAX   = STAB_W'(STABLE_CYCLES - 1);
  localparam logic [FLASH_W-1:0]  FLASH_LOAD = FLASH_W'(FLASH_CYCLES - 1);
  localparam logic [PWM_BITS-1:0] DUTY_C     = PWM_BITS'(DUTY);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FLASH = 2'd1;
  localparam logic [1:0] S_DIM   = 2'd2;

  // --------------------------------------------------------------------------
  // Signals
  // --------------------------------------------------------------------------
  logic [2:0]          meta_q;
  logic [2:0]          sync_q;

  logic [2:0]          cand_q,    cand_d;
  logic [STAB_W-1:0]   stab_q,    stab_d;
  logic [2:0]          pattern_q, pattern_d;
  logic                valid_q;
  logic                accept;

  logic [PWM_BITS-1:0] pwm_q,     pwm_d;
  logic                pwm_on_d;

  logic [1:0]          state_q,   state_d;
  logic [FLASH_W-1:0]  flash_q,   flash_d;

  logic [2:0]          led_q,     led_d;
  logic                blink_lit;

  // --------------------------------------------------------------------------
  // Two-flop synchroniser for the asynchronous comparator flags {r,g,b}
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 3'b000;
      sync_q <= 3'b000;
    end else begin
      meta_q <= {r_in, g_in, b_in};
      sync_q <= meta_q;
    end
  end

  // --------------------------------------------------------------------------
  // Debounce filter: a candidate must stay equal for STABLE_CYCLES synced
  // samples. Acceptance is decided on the next-state count so that pattern
  // and pattern_valid update together on the qualifying edge.
  // --------------------------------------------------------------------------
  always_comb begin
    cand_d = cand_q;
    stab_d = stab_q;
    if (sync_q != cand_q) begin
      cand_d = sync_q;
      stab_d = '0;
    end else if (stab_q != STAB_MAX) begin
      stab_d = stab_q + 1'b1;
    end
    accept    = (stab_d == STAB_MAX) && (cand_d != pattern_q);
    pattern_d = accept ? cand_d : pattern_q;
  end

  // Filter state, accepted pattern and its one-cycle change pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_q    <= 3'b000;
      stab_q    <= '0;
      pattern_q <= 3'b000;
      valid_q   <= 1'b0;
    end else begin
      cand_q    <= cand_d;
      stab_q    <= stab_d;
      pattern_q <= pattern_d;
      valid_q   <= accept;
    end
  end

  // --------------------------------------------------------------------------
  // Free-running PWM counter; on-decision uses the next count so the
  // registered LED lines up with pwm_q.
  // --------------------------------------------------------------------------
  always_comb begin
    pwm_d    = pwm_q + 1'b1;
    pwm_on_d = (pwm_d < DUTY_C);
  end

  // PWM counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_q <= '0;
    end else begin
      pwm_q <= pwm_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state. A newly accepted pattern wins over flash expiry; an
  // all-zero pattern always returns to IDLE.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    flash_d = flash_q;
    if (accept) begin
      if (cand_d == 3'b000) begin
        state_d = S_IDLE;
      end else begin
        state_d = S_FLASH;
        flash_d = FLASH_LOAD;
      end
    end else begin
      case (state_q)
        S_IDLE:  state_d = S_IDLE;
        S_FLASH: begin
          if (flash_q == '0) begin
            state_d = S_DIM;
          end else begin
            flash_d = flash_q - 1'b1;
          end
        end
        S_DIM:   state_d = S_DIM;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FSM and flash counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      flash_q <= '0;
    end else begin
      state_q <= state_d;
      flash_q <= flash_d;
    end
  end

  // --------------------------------------------------------------------------
  // Optional blink gate for the DIM state
  // --------------------------------------------------------------------------
`ifdef CMP_LED_BLINK_EN
  logic [BLINK_BITS-1:0] blink_q, blink_d;

  // Blink counter restarts on each entry to DIM so the LED starts lit
  always_comb begin
    if ((state_d == S_DIM) && (state_q != S_DIM)) begin
      blink_d = '0;
    end else begin
      blink_d = blink_q + 1'b1;
    end
    blink_lit = ~blink_d[BLINK_BITS-1];
  end

  // Blink counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_q <= '0;
    end else begin
      blink_q <= blink_d;
    end
  end
`else
  // Without blinking the dimmed pattern is steady PWM
  always_comb begin
    blink_lit = 1'b1;
  end
`endif

  // --------------------------------------------------------------------------
  // LED drive decoded from next-state values
  // --------------------------------------------------------------------------
  always_comb begin
    led_d = 3'b000;
    case (state_d)
      S_FLASH: led_d = pattern_d;
      S_DIM:   led_d = pattern_d & {3{pwm_on_d & blink_lit}};
      default: led_d = 3'b000;
    endcase
  end

  // Registered LED outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q <= 3'b000;
    end else begin
      led_q <= led_d;
    end
  end

  assign led_r         = led_q[2];
  assign led_g         = led_q[1];
  assign led_b         = led_q[0];
  assign pattern       = pattern_q;
  assign pattern_valid = valid_q;

endmodule
`default_nettype wire
